// File: rtl/skid_buffer_x65.sv
// Two-entry elastic stage (main + skid) between a valid/ready producer and
// a valid/ready consumer. It sustains one transfer per cycle. in_ready and
// out_valid come straight from flops, so no combinational path crosses the
// stage in either direction.
//
// state    | {skid_valid, main_valid} | meaning
// ---------+--------------------------+-----------------------------------
// ST_EMPTY | 00                       | nothing held, upstream may push
// ST_ONE   | 01                       | main holds the head, room for one
// ST_TWO   | 11                       | main = head, skid = next, stalled
// (10)     | --                       | illegal, recovers to ST_EMPTY

module skid_buffer_x65 #(
  parameter int LENGTH = 65
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [LENGTH-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [LENGTH-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [LENGTH-1:0] main_q, main_d;
  logic [LENGTH-1:0] skid_q, skid_d;
  logic [1:0]        state_bits;
  logic              main_valid;
  logic              skid_valid;
  logic              in_xfer;
  logic              out_xfer;

  assign state_bits = state_q;
  assign main_valid = state_bits[0];
  assign skid_valid = state_bits[1];

  // The handshake outputs decode registered state only. The illegal 10
  // encoding reports neither ready nor valid until it recovers.
  assign in_ready  = (state_q == ST_EMPTY) || (state_q == ST_ONE);
  assign out_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign out_data  = main_q;
  assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Next-state and payload steering. Each data register loads only on its
  // own transfer or move and holds otherwise.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          skid_d  = in_data;
          state_d = ST_TWO;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // Upstream sees in_ready=0 here, so in_valid cannot transfer.
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush drops everything, including an entry arriving this cycle. The
    // payload keeps its old value because out_valid=0 masks it anyway. A
    // pop in the same cycle has already completed its handshake downstream.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // State and payload registers. Reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_skid_buffer_x65.sv
// Bench for skid_buffer_x65: a directed vector table, hand sequences for
// reset and streaming, and random traffic scored against a queue model.

module tb_skid_buffer_x65;

  localparam int W = 65;

  logic         clk = 1'b0;
  logic         clk_en = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   count;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] q[$];

  typedef struct {
    logic         fl;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         e_ov;
    logic         e_ir;
    logic [1:0]   e_cnt;
    logic [W-1:0] e_data;
  } vec_t;

  vec_t vecs[16];

  skid_buffer_x65 #(.LENGTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, and advance the reference queue.
  task automatic cycle(input logic fl, input logic iv, input logic [W-1:0] d, input logic ordy);
    bit do_pop;
    bit do_push;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    do_pop  = reset && (q.size() > 0) && ordy;
    do_push = reset && (q.size() < 2) && iv;
    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(d);
    if (fl && reset) q.delete();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"}, W'(count), W'(q.size()));
    chk({tag, ".out_valid"}, W'(out_valid), W'(q.size() > 0));
    chk({tag, ".in_ready"}, W'(in_ready), W'(q.size() < 2));
    if (q.size() > 0) chk({tag, ".out_data"}, out_data, q[0]);
  endtask

  function automatic logic [W-1:0] rnd65();
    logic [W-1:0] r;
    logic [31:0]  t;
    r[31:0]  = $urandom;
    r[63:32] = $urandom;
    t        = $urandom;
    r[64]    = t[0];
    return r;
  endfunction

  initial begin
    logic [W-1:0] pat;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Async reset with the clock stopped.
    #2 reset = 1'b0;
    #3;
    chk("rst.out_valid", W'(out_valid), W'(0));
    chk("rst.in_ready", W'(in_ready), W'(1));
    chk("rst.count", W'(count), W'(0));
    chk("rst.out_data", out_data, W'(0));

    clk_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;

    // Directed table; expectations are the state right after each edge.
    //            fl    iv    data                          ordy  ov    ir    cnt   data
    vecs[0]  = '{1'b0, 1'b1, 65'h1_DEAD_BEEF_0000_0001, 1'b1, 1'b1, 1'b1, 2'd1, 65'h1_DEAD_BEEF_0000_0001};
    vecs[1]  = '{1'b0, 1'b0, 65'h0,                     1'b1, 1'b0, 1'b1, 2'd0, 65'h0};
    vecs[2]  = '{1'b0, 1'b1, 65'h0_0000_0000_0000_00A1, 1'b0, 1'b1, 1'b1, 2'd1, 65'h0_0000_0000_0000_00A1};
    vecs[3]  = '{1'b0, 1'b1, 65'h1_0000_0000_0000_00B2, 1'b0, 1'b1, 1'b0, 2'd2, 65'h0_0000_0000_0000_00A1};
    vecs[4]  = '{1'b0, 1'b1, 65'h0_0000_0000_0000_00C3, 1'b0, 1'b1, 1'b0, 2'd2, 65'h0_0000_0000_0000_00A1};
    vecs[5]  = '{1'b0, 1'b1, 65'h0_0000_0000_0000_00C3, 1'b1, 1'b1, 1'b1, 2'd1, 65'h1_0000_0000_0000_00B2};
    vecs[6]  = '{1'b0, 1'b1, 65'h0_0000_0000_0000_00C3, 1'b1, 1'b1, 1'b1, 2'd1, 65'h0_0000_0000_0000_00C3};
    vecs[7]  = '{1'b0, 1'b0, 65'h0,                     1'b1, 1'b0, 1'b1, 2'd0, 65'h0};
    vecs[8]  = '{1'b0, 1'b1, 65'h1_0000_0000_0000_0011, 1'b0, 1'b1, 1'b1, 2'd1, 65'h1_0000_0000_0000_0011};
    vecs[9]  = '{1'b0, 1'b1, 65'h1_0000_0000_0000_0022, 1'b0, 1'b1, 1'b0, 2'd2, 65'h1_0000_0000_0000_0011};
    vecs[10] = '{1'b1, 1'b1, 65'h0_0000_0000_0000_00DD, 1'b0, 1'b0, 1'b1, 2'd0, 65'h0};
    vecs[11] = '{1'b1, 1'b1, 65'h0_0000_0000_0000_00EE, 1'b0, 1'b0, 1'b1, 2'd0, 65'h0};
    vecs[12] = '{1'b0, 1'b0, 65'h0,                     1'b0, 1'b0, 1'b1, 2'd0, 65'h0};
    vecs[13] = '{1'b0, 1'b1, 65'h0_0000_0000_0000_00F1, 1'b1, 1'b1, 1'b1, 2'd1, 65'h0_0000_0000_0000_00F1};
    vecs[14] = '{1'b0, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFF2, 1'b0, 1'b1, 1'b0, 2'd2, 65'h0_0000_0000_0000_00F1};
    vecs[15] = '{1'b1, 1'b0, 65'h0,                     1'b1, 1'b0, 1'b1, 2'd0, 65'h0};

    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      chk($sformatf("vec%0d.out_valid", i), W'(out_valid), W'(vecs[i].e_ov));
      chk($sformatf("vec%0d.in_ready", i), W'(in_ready), W'(vecs[i].e_ir));
      chk($sformatf("vec%0d.count", i), W'(count), W'(vecs[i].e_cnt));
      if (vecs[i].e_ov) chk($sformatf("vec%0d.out_data", i), out_data, vecs[i].e_data);
    end

    // Streaming: back-to-back pushes come out on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, W'(i), 1'b1);
      chk($sformatf("stream%0d.out_data", i), out_data, W'(i));
      chk($sformatf("stream%0d.out_valid", i), W'(out_valid), W'(1));
      chk($sformatf("stream%0d.in_ready", i), W'(in_ready), W'(1));
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("stream.drain.count", W'(count), W'(0));

    // Reset between edges while two entries are held.
    cycle(1'b0, 1'b1, 65'h0_0000_0000_0000_0AAA, 1'b0);
    cycle(1'b0, 1'b1, 65'h0_0000_0000_0000_0BBB, 1'b0);
    chk("midrst.pre.count", W'(count), W'(2));
    #2 reset = 1'b0;
    q.delete();
    #1;
    chk("midrst.out_valid", W'(out_valid), W'(0));
    chk("midrst.count", W'(count), W'(0));
    chk("midrst.in_ready", W'(in_ready), W'(1));
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 65'h0_0000_0000_0000_1234, 1'b1);
    chk("midrst.push.out_valid", W'(out_valid), W'(1));
    chk("midrst.push.out_data", out_data, 65'h0_0000_0000_0000_1234);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("midrst.pop.count", W'(count), W'(0));

    // Random traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      pat = rnd65();
      cycle(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), pat,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'($urandom_range(0, 1)));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
